edge_slope_setup: RTL
=====================

Name: edge_slope_setup

Overview:
- Triangle-setup stage directly upstream of divider_21bits.
- Accepts one triangle (three screen-space vertices) and forms each edge's dx/dy.
- Issues up to three signed divisions to the divider over its open/finish handshake, and collects the quotients as Q(COORD_W+1).FRAC_W edge slopes for the rasteriser.
- Edges with dy==0 never reach the divider.

Parameters:
- COORD_W, 10, unsigned vertex coordinate width.
- FRAC_W, 10, fractional bits of slope result.
- DIV_W, 21, divider operand/quotient width; must equal COORD_W+1+FRAC_W (elaboration error otherwise).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tri_valid  in  1  triangle input valid.
- tri_ready  out  1  block can accept a triangle.
- x0,y0,x1,y1,x2,y2  in  COORD_W each  vertex coordinates, unsigned.
- div_open  out  1  divide request to divider_21bits.
- div_dividend  out  DIV_W  signed dividend.
- div_divisor  out  DIV_W  signed divisor.
- div_finish  in  1  divider result valid.
- div_quotient  in  DIV_W  signed quotient.
- slope_valid  out  1  slopes ready.
- slope_ready  in  1  downstream accepts.
- slope0,slope1,slope2  out  DIV_W each  signed slopes for E0 (v0->v1), E1 (v1->v2), E2 (v2->v0).
- horiz  out  3  bit k set when edge k has dy==0.

Behaviour:
- Reset: all outputs 0 except tri_ready=1. FSM goes to IDLE and the edge index to 0.
  - Asserting rst_n low mid-division drops div_open immediately and discards any partial triangle.
- Edge k arithmetic:
  - dx = x_end - x_start and dy = y_end - y_start, each sign-extended to COORD_W+1 bits.
  - dividend = dx << FRAC_W, sign-extended to DIV_W.
  - divisor = dy, sign-extended to DIV_W.
- States:
  - IDLE: tri_ready=1. On tri_valid, latch all six coordinates, set tri_ready=0, k=0, go to SETUP.
  - SETUP (1 cycle): compute dx/dy for edge k and register the operands.
    - If dy==0: slope_k=0, horiz[k]=1, go to NEXT without touching the divider.
    - Otherwise horiz[k]=0, go to REQ.
  - REQ: div_open=1. Operands are held stable from the first open cycle until finish is sampled. Wait for div_finish==1.
    - In the first cycle div_finish is seen high, capture div_quotient into slope_k, drop div_open next cycle, go to GAP.
    - div_finish already high on the first REQ cycle is a stale result: ignore it and wait for finish to go low then high.
  - GAP (1 cycle): div_open=0. Guarantees a low cycle between requests so the divider restarts. Go to NEXT.
  - NEXT: if k==2 go to OUT, else k=k+1 and go to SETUP.
  - OUT: slope_valid=1. slope0..2 and horiz are stable while valid. On slope_valid&&slope_ready, clear slope_valid, go to IDLE. No new triangle is accepted before the handoff.
- Latency:
  - With no horizontal edges: 1 (accept) + 3*(1 SETUP + divider latency + 1 GAP + 1 NEXT) + 1 to OUT.
  - Horizontal edges skip REQ and GAP.
- Degenerate triangle (all vertices equal): horiz=3'b111, all slopes 0, zero divider requests.
- Quotient is taken verbatim; no saturation in this block.

Decomposition:
- Shared package `render_pkg`:
  - COORD_W, FRAC_W, DIV_W constants.
  - FSM state enum {IDLE, SETUP, REQ, GAP, NEXT, OUT}.
  - Edge-index typedef.
- One natural sub-module: `edge_delta`, combinational. Takes start/end vertex and returns sign-extended dx, dy, dy_zero and the shifted dividend. Instantiated once and muxed by k.

Test Plan:
- Triangle (0,0),(100,50),(20,80) with a behavioural divider of 5-cycle latency:
  - E0: dividend=100<<10, divisor=50 -> slope0=0x00800 (2.0).
  - E1: dx=-80, dy=30 -> slope1=-2730 (truncated).
  - E2: dx=-20, dy=-80 -> slope2=256.
  - horiz=000; exactly 3 open pulses, each separated by >=1 low cycle.
- Flat-top triangle (10,20),(50,20),(30,60):
  - Required: horiz=001, slope0=0, only 2 divider requests, slope_valid asserted.
- All vertices (5,5):
  - Required: horiz=111, div_open never asserts, slope_valid within 8 cycles of tri_valid.
- Backpressure: hold slope_ready=0 for 20 cycles.
  - Required: slopes and horiz stable, tri_ready=0, a new tri_valid is ignored.
  - On slope_ready=1: handoff in 1 cycle, then tri_ready=1.
- rst_n pulled low while in REQ:
  - Required: div_open=0 and slope_valid=0 asynchronously, tri_ready=1 after release.
  - Next triangle processes correctly.
- div_finish held high from a previous op when REQ is entered:
  - Required: the block does not capture until finish falls and rises again, and the quotient captured is the new one.

Source files
------------

// File: rtl/render_pkg.sv
// Shared constants and types for the triangle-setup front end.
package render_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned FRAC_W  = 10;
   localparam int unsigned DIV_W   = 21;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      REQ,
      GAP,
      NEXT,
      OUT
   } state_e;

   typedef logic [1:0] edge_idx_t;

   localparam edge_idx_t LAST_EDGE = 2'd2;

endpackage

// File: rtl/edge_delta.sv
// Per-edge deltas: sign-extended dy, dy==0 flag and the fixed-point dividend dx<<FRAC_W.
module edge_delta #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned FRAC_W  = 10,
   parameter int unsigned DIV_W   = 21
) (
   input  logic [COORD_W-1:0] i_xs,
   input  logic [COORD_W-1:0] i_ys,
   input  logic [COORD_W-1:0] i_xe,
   input  logic [COORD_W-1:0] i_ye,
   output logic [COORD_W:0]   o_dy,
   output logic               o_dy_zero,
   output logic [DIV_W-1:0]   o_dividend
);

   logic signed [COORD_W:0] w_dx;
   logic signed [COORD_W:0] w_dy;

   // Zero-extend the unsigned coordinates by one bit so the difference is exact in two's complement.
   assign w_dx = $signed({1'b0, i_xe}) - $signed({1'b0, i_xs});
   assign w_dy = $signed({1'b0, i_ye}) - $signed({1'b0, i_ys});

   assign o_dy       = w_dy;
   assign o_dy_zero  = (w_dy == '0);
   assign o_dividend = {w_dx, {FRAC_W{1'b0}}};

endmodule

// File: rtl/edge_slope_setup.sv
// Triangle setup: per-edge dx/dy, sequenced signed divides, collected fixed-point edge slopes.
module edge_slope_setup #(
   parameter int unsigned COORD_W = render_pkg::COORD_W,
   parameter int unsigned FRAC_W  = render_pkg::FRAC_W,
   parameter int unsigned DIV_W   = render_pkg::DIV_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   output logic               div_open,
   output logic [DIV_W-1:0]   div_dividend,
   output logic [DIV_W-1:0]   div_divisor,
   input  logic               div_finish,
   input  logic [DIV_W-1:0]   div_quotient,
   output logic               slope_valid,
   input  logic               slope_ready,
   output logic [DIV_W-1:0]   slope0,
   output logic [DIV_W-1:0]   slope1,
   output logic [DIV_W-1:0]   slope2,
   output logic [2:0]         horiz
);

   import render_pkg::*;

   if (DIV_W != COORD_W + 1 + FRAC_W) begin : g_bad_div_w
      $error("edge_slope_setup: DIV_W must equal COORD_W+1+FRAC_W");
   end

   state_e            r_state;
   state_e            w_state_nxt;
   edge_idx_t         r_k;
   logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
   logic              r_seen_low;
   logic              r_tri_ready;
   logic              r_div_open;
   logic              r_slope_valid;
   logic [DIV_W-1:0]  r_dividend;
   logic [DIV_W-1:0]  r_divisor;
   logic [DIV_W-1:0]  r_slope0, r_slope1, r_slope2;
   logic [2:0]        r_horiz;

   logic [COORD_W-1:0] w_xs, w_ys, w_xe, w_ye;
   logic [COORD_W:0]   w_dy;
   logic               w_dy_zero;
   logic [DIV_W-1:0]   w_dividend;
   logic               w_accept;
   logic               w_capture;
   logic               w_slope_we;
   logic [DIV_W-1:0]   w_slope_din;
   logic               w_tri_ready_d;
   logic               w_div_open_d;
   logic               w_slope_valid_d;

   // Edge k runs v0->v1, v1->v2, v2->v0.
   always_comb begin
      w_xs = r_x0;
      w_ys = r_y0;
      w_xe = r_x1;
      w_ye = r_y1;
      case (r_k)
         2'd1: begin
            w_xs = r_x1; w_ys = r_y1; w_xe = r_x2; w_ye = r_y2;
         end
         2'd2: begin
            w_xs = r_x2; w_ys = r_y2; w_xe = r_x0; w_ye = r_y0;
         end
         default: ;
      endcase
   end

   edge_delta #(
      .COORD_W (COORD_W),
      .FRAC_W  (FRAC_W),
      .DIV_W   (DIV_W)
   ) u_edge_delta (
      .i_xs       (w_xs),
      .i_ys       (w_ys),
      .i_xe       (w_xe),
      .i_ye       (w_ye),
      .o_dy       (w_dy),
      .o_dy_zero  (w_dy_zero),
      .o_dividend (w_dividend)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // A finish that was already high when REQ started is stale; only a low-then-high finish counts.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (tri_valid) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = w_dy_zero ? NEXT : REQ;
         REQ:     if (div_finish && r_seen_low) w_state_nxt = GAP;
         GAP:     w_state_nxt = NEXT;
         NEXT:    w_state_nxt = (r_k == LAST_EDGE) ? OUT : SETUP;
         OUT:     if (slope_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_accept        = (r_state == IDLE) && tri_valid;
      w_capture       = (r_state == REQ) && div_finish && r_seen_low;
      w_slope_we      = ((r_state == SETUP) && w_dy_zero) || w_capture;
      w_slope_din     = w_capture ? div_quotient : '0;
      w_tri_ready_d   = (w_state_nxt == IDLE);
      w_div_open_d    = (w_state_nxt == REQ);
      w_slope_valid_d = (w_state_nxt == OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k           <= '0;
         r_x0          <= '0;
         r_y0          <= '0;
         r_x1          <= '0;
         r_y1          <= '0;
         r_x2          <= '0;
         r_y2          <= '0;
         r_seen_low    <= 1'b0;
         r_tri_ready   <= 1'b1;
         r_div_open    <= 1'b0;
         r_slope_valid <= 1'b0;
         r_dividend    <= '0;
         r_divisor     <= '0;
         r_slope0      <= '0;
         r_slope1      <= '0;
         r_slope2      <= '0;
         r_horiz       <= '0;
      end else begin
         r_tri_ready   <= w_tri_ready_d;
         r_div_open    <= w_div_open_d;
         r_slope_valid <= w_slope_valid_d;

         if (w_accept) begin
            r_x0 <= x0; r_y0 <= y0;
            r_x1 <= x1; r_y1 <= y1;
            r_x2 <= x2; r_y2 <= y2;
            r_k  <= '0;
         end

         // Operands are only loaded here, so they stay put for the whole request.
         if (r_state == SETUP) begin
            r_dividend <= w_dividend;
            r_divisor  <= {{FRAC_W{w_dy[COORD_W]}}, w_dy};
            r_seen_low <= 1'b0;
            case (r_k)
               2'd0:    r_horiz[0] <= w_dy_zero;
               2'd1:    r_horiz[1] <= w_dy_zero;
               default: r_horiz[2] <= w_dy_zero;
            endcase
         end

         if ((r_state == REQ) && !div_finish) r_seen_low <= 1'b1;

         if (w_slope_we) begin
            case (r_k)
               2'd0:    r_slope0 <= w_slope_din;
               2'd1:    r_slope1 <= w_slope_din;
               default: r_slope2 <= w_slope_din;
            endcase
         end

         if ((r_state == NEXT) && (r_k != LAST_EDGE)) r_k <= r_k + 2'd1;
      end
   end

   assign tri_ready    = r_tri_ready;
   assign div_open     = r_div_open;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign slope_valid  = r_slope_valid;
   assign slope0       = r_slope0;
   assign slope1       = r_slope1;
   assign slope2       = r_slope2;
   assign horiz        = r_horiz;

endmodule
